queue_calc_sequencer: RTL
=========================

QUEUE_CALC_SEQUENCER -- requirements
Module: queue_calc_sequencer

Interface
REQ-001 SHALL have port clk, input, 1 bit: clock; all state changes on rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-003 SHALL have port tok_valid, input, 1 bit: token offered.
REQ-004 SHALL have port tok_ready, output, 1 bit: sequencer can accept a token.
REQ-005 SHALL have port tok_is_op, input, 1 bit: 1 = operator token, 0 = operand token.
REQ-006 SHALL have port tok_data, input, 8 bits: operand value, or operator code in bits [1:0].
REQ-007 SHALL have port q_en, output, 1 bit: queue command strobe.
REQ-008 SHALL have port q_opcode, output, 2 bits: queue command; 00 push, 10 pop-pair-push-result, 11 pop-front.
REQ-009 SHALL have port q_back, output, 8 bits: data pushed to the queue back.
REQ-010 SHALL have port top_conc, input, 16 bits: queue front pair {front, second}.
REQ-011 SHALL have port res_valid, output, 1 bit: one-cycle result pulse.
REQ-012 SHALL have port res_data, output, 8 bits: emitted result.
REQ-013 SHALL have port depth, output, 3 bits: tracked queue occupancy, range 0..5.
REQ-014 SHALL have port err, output, 1 bit: sticky underflow/overflow flag.

Function
REQ-015 SHALL implement FSM states IDLE, ISSUE, ERR.
REQ-016 SHALL assert tok_ready only in IDLE; a token is accepted when tok_valid and tok_ready are both 1 on a rising edge.
REQ-017 SHALL register the accepted token and enter ISSUE on the next cycle, or enter ERR if the token is illegal.
REQ-018 SHALL drive q_en high for exactly one cycle in ISSUE and return to IDLE, giving one token per 2 cycles.
REQ-019 SHALL, for an operand token, issue q_opcode 00 with q_back = operand and increment depth; the token is illegal if depth = 5.
REQ-020 SHALL, for operator codes 00 add, 01 sub, 10 mul, issue q_opcode 10 with q_back = ALU(a, b), where a = top_conc[15:8], b = top_conc[7:0], and decrement depth by 1.
REQ-021 SHALL treat the arithmetic operators as illegal if depth < 2.
REQ-022 SHALL compute arithmetic modulo 256: add a+b; sub a-b; mul low 8 bits of a*b.
REQ-023 SHALL, for operator code 11 (emit), issue q_opcode 11, pulse res_valid with res_data = top_conc[15:8] in the same ISSUE cycle, and decrement depth.
REQ-024 SHALL treat emit as illegal if depth = 0.
REQ-025 SHALL, on an illegal token, make no queue command, set err = 1, and stay in ERR with tok_ready = 0 until rst.
REQ-026 SHALL, outside ISSUE, hold q_en = 0, res_valid = 0, and q_opcode = 00.
REQ-027 SHALL sample top_conc in ISSUE; the queue reflects the previous command by then.
REQ-028 SHALL hold res_data at its last emitted value between pulses.

Reset
REQ-029 SHALL, on rst, set state IDLE, depth 0, err 0, q_en 0, q_opcode 00, q_back 0, res_valid 0, and res_data 0.
REQ-030 SHALL give rst priority over all activity: rst asserted during ISSUE cancels pending state, and q_en is 0 in the following cycle.
REQ-031 SHALL drive tok_ready 0 in the cycle rst is high and 1 in the first cycle after.

Structure
REQ-032 SHALL import from shared package queue_calc_pkg: queue opcode constants, operator code constants, queue depth constant (5), and FSM state type.
REQ-033 SHALL place the arithmetic in combinational sub-module queue_calc_alu (inputs a, b, op; output 8-bit result).
REQ-034 SHALL be verifiable against a behavioural 5-entry FIFO queue model connected at q_*/top_conc.

Verification
REQ-035 Bench SHALL cover: operands 3, 4, then op add, then emit -> q_back 3, 4, 7 pushed; res_valid pulse with res_data 7; depth 0 at end.
REQ-036 Bench SHALL cover: operands 5, 9, op sub, emit -> res_data 0xFC.
REQ-037 Bench SHALL cover: operands 0x20, 0x10, op mul, emit -> res_data 0x00.
REQ-038 Bench SHALL cover: six operands back to back -> first five pushed, depth 5; sixth sets err 1, no q_en, tok_ready stays 0.
REQ-039 Bench SHALL cover: emit with depth 0 after reset -> err 1, res_valid never pulses.
REQ-040 Bench SHALL cover: rst asserted in an ISSUE cycle -> next cycle q_en 0, depth 0, err 0, tok_ready 1 one cycle after rst deasserts.

Source files
------------

// File: rtl/queue_calc_pkg.sv
// Shared constants and types for the queue-driven calculator sequencer.
// Covers queue command codes, operator codes, queue capacity and FSM states.
package queue_calc_pkg;

    localparam logic [1:0] Q_PUSH      = 2'b00;
    localparam logic [1:0] Q_POP_PAIR  = 2'b10;
    localparam logic [1:0] Q_POP_FRONT = 2'b11;

    localparam logic [1:0] OP_ADD  = 2'b00;
    localparam logic [1:0] OP_SUB  = 2'b01;
    localparam logic [1:0] OP_MUL  = 2'b10;
    localparam logic [1:0] OP_EMIT = 2'b11;

    localparam logic [2:0] QUEUE_DEPTH = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ISSUE = 2'b01,
        ST_ERR   = 2'b10
    } state_t;

    // A token is illegal when it would overflow or underflow the tracked queue.
    function automatic logic tok_illegal(input logic       is_op,
                                         input logic [1:0] op,
                                         input logic [2:0] depth);
        logic bad;
        if (!is_op) begin
            bad = (depth >= QUEUE_DEPTH);
        end else if (op == OP_EMIT) begin
            bad = (depth == 3'd0);
        end else begin
            bad = (depth < 3'd2);
        end
        return bad;
    endfunction

endpackage

// File: rtl/queue_calc_alu.sv
// Combinational 8-bit ALU: add, sub and low byte of multiply, all modulo 256.
module queue_calc_alu
    import queue_calc_pkg::*;
(
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic [1:0] op,
    output logic [7:0] result
);

    logic [15:0] prod_s;

    assign prod_s = 16'(a) * 16'(b);

    // Operator select; emit never reaches the ALU result path.
    always_comb begin
        case (op)
            OP_ADD:  result = a + b;
            OP_SUB:  result = a - b;
            OP_MUL:  result = prod_s[7:0];
            default: result = 8'h00;
        endcase
    end

endmodule

// File: rtl/queue_calc_sequencer.sv
// Token sequencer: turns operand/operator tokens into commands for an external
// 5-entry queue, tracks its occupancy, and latches a sticky error on misuse.
module queue_calc_sequencer
    import queue_calc_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        tok_valid,
    output logic        tok_ready,
    input  logic        tok_is_op,
    input  logic [7:0]  tok_data,
    output logic        q_en,
    output logic [1:0]  q_opcode,
    output logic [7:0]  q_back,
    input  logic [15:0] top_conc,
    output logic        res_valid,
    output logic [7:0]  res_data,
    output logic [2:0]  depth,
    output logic        err
);

    state_t      state_r;
    state_t      state_s;
    logic        tok_is_op_r;
    logic [7:0]  tok_data_r;
    logic [2:0]  depth_r;
    logic        err_r;
    logic [7:0]  res_data_r;
    logic        accept_s;
    logic        illegal_s;
    logic [7:0]  alu_y_s;

    queue_calc_alu u_alu (
        .a      (top_conc[15:8]),
        .b      (top_conc[7:0]),
        .op     (tok_data_r[1:0]),
        .result (alu_y_s)
    );

    assign accept_s  = tok_valid & tok_ready;
    assign illegal_s = tok_illegal(tok_is_op, tok_data[1:0], depth_r);
    assign depth     = depth_r;
    assign err       = err_r;

    // Next-state and command decode; reset suppresses every strobe in its cycle.
    always_comb begin
        state_s   = state_r;
        tok_ready = 1'b0;
        q_en      = 1'b0;
        q_opcode  = Q_PUSH;
        q_back    = 8'h00;
        res_valid = 1'b0;
        res_data  = res_data_r;
        if (rst) begin
            state_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    tok_ready = 1'b1;
                    if (tok_valid) begin
                        state_s = illegal_s ? ST_ERR : ST_ISSUE;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end
                ST_ISSUE: begin
                    q_en    = 1'b1;
                    state_s = ST_IDLE;
                    if (!tok_is_op_r) begin
                        q_opcode = Q_PUSH;
                        q_back   = tok_data_r;
                    end else if (tok_data_r[1:0] == OP_EMIT) begin
                        q_opcode  = Q_POP_FRONT;
                        res_valid = 1'b1;
                        res_data  = top_conc[15:8];
                    end else begin
                        q_opcode = Q_POP_PAIR;
                        q_back   = alu_y_s;
                    end
                end
                ST_ERR: begin
                    state_s = ST_ERR;
                end
                default: begin
                    state_s = ST_IDLE;
                end
            endcase
        end
    end

    // State, captured token, occupancy, sticky error and held result.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            tok_is_op_r <= 1'b0;
            tok_data_r  <= 8'h00;
            depth_r     <= 3'd0;
            err_r       <= 1'b0;
            res_data_r  <= 8'h00;
        end else begin
            state_r <= state_s;
            if (accept_s) begin
                tok_is_op_r <= tok_is_op;
                tok_data_r  <= tok_data;
            end
            if (accept_s && illegal_s) begin
                err_r <= 1'b1;
            end
            if (state_r == ST_ISSUE) begin
                depth_r <= tok_is_op_r ? (depth_r - 3'd1) : (depth_r + 3'd1);
            end
            if (res_valid) begin
                res_data_r <= top_conc[15:8];
            end
        end
    end

endmodule
